// File: rtl/diffeq_pkg.sv
// Shared types for the diffeq job sequencer: FSM states, the job descriptor
// and result record at the default solver word width, and a small decode
// helper used to derive the solver reset from the sequencer state.
package diffeq_pkg;

  // Default data word width of the diffeq solver ports.
  localparam int DEFAULT_WIDTH = 32;

  // Sequencer phases around one solver job.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // One queued job: initial X/Y/U, x limit A and step DX.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] x;
    logic [DEFAULT_WIDTH-1:0] y;
    logic [DEFAULT_WIDTH-1:0] u;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] dx;
  } job_t;

  // One captured result with its watchdog flag.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] x;
    logic [DEFAULT_WIDTH-1:0] y;
    logic [DEFAULT_WIDTH-1:0] u;
    logic                     timeout;
  } result_t;

  // The solver is held in reset whenever no job is being loaded or run.
  function automatic logic solver_held(input state_e s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/diffeq_job_fifo.sv
// Synchronous FIFO of job descriptors. Power-of-two depth so the read and
// write pointers wrap naturally; an occupancy counter gives full/empty/count.
// A push while full is accepted only together with a pop.
module diffeq_job_fifo
  import diffeq_pkg::*;
#(
  parameter type entry_t = job_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == COUNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale data is never read.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/diffeq_job_sequencer.sv
// Upstream feeder for the diffeq solver core. Jobs are queued in a small
// FIFO, then presented one at a time on the solver operand ports, which stay
// stable from load until the next job. A shadow copy of the solver's x
// iteration tells the sequencer exactly when the solver outputs are final;
// an iteration watchdog aborts jobs that never reach A. Results are held in
// a valid/ready channel, and a new job starts only once that slot is free.
module diffeq_job_sequencer
  import diffeq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = 4,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             reset,
  // job intake
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [WIDTH-1:0] job_x,
  input  logic [WIDTH-1:0] job_y,
  input  logic [WIDTH-1:0] job_u,
  input  logic [WIDTH-1:0] job_a,
  input  logic [WIDTH-1:0] job_dx,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_x,
  output logic [WIDTH-1:0] res_y,
  output logic [WIDTH-1:0] res_u,
  output logic             res_timeout,
  // solver interface
  output logic             sol_reset,
  output logic [WIDTH-1:0] sol_xin,
  output logic [WIDTH-1:0] sol_yin,
  output logic [WIDTH-1:0] sol_uin,
  output logic [WIDTH-1:0] sol_a,
  output logic [WIDTH-1:0] sol_dx,
  input  logic [WIDTH-1:0] sol_xout,
  input  logic [WIDTH-1:0] sol_yout,
  input  logic [WIDTH-1:0] sol_uout
);

  localparam int ITER_W  = $clog2(MAX_ITER + 1);
  localparam int COUNT_W = $clog2(DEPTH) + 1;
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  // Job record at this instance's word width.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] dx;
  } job_w_t;

  state_e              state;
  logic [WIDTH-1:0]    shadow_x;
  logic [ITER_W-1:0]   iter;
  logic                tmo;

  job_w_t              push_job;
  job_w_t              head_job;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [COUNT_W-1:0]  fifo_count;
  logic                res_hs;
  logic                x_below_a;

  assign push_job  = '{x: job_x, y: job_y, u: job_u, a: job_a, dx: job_dx};
  assign job_ready = (fifo_count != COUNT_W'(DEPTH));
  assign push      = job_valid && !fifo_full;
  assign res_hs    = res_valid && res_ready;
  // Start the next job only when the result slot is empty or being drained.
  assign pop       = (state == IDLE) && !fifo_empty && (!res_valid || res_ready);
  assign x_below_a = (shadow_x < sol_a);
  // Reset input ORed with a decode of the state flops; no other logic.
  assign sol_reset = reset || solver_held(state);

  diffeq_job_fifo #(
    .entry_t (job_w_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .pop_data  (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Job sequencing FSM: load operands, mirror x, capture and hand off result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow_x    <= '0;
      iter        <= '0;
      tmo         <= 1'b0;
      sol_xin     <= '0;
      sol_yin     <= '0;
      sol_uin     <= '0;
      sol_a       <= '0;
      sol_dx      <= '0;
      res_valid   <= 1'b0;
      res_x       <= '0;
      res_y       <= '0;
      res_u       <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (res_hs) res_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          // Operands only ever change here, while the solver is in reset.
          if (pop) begin
            sol_xin <= head_job.x;
            sol_yin <= head_job.y;
            sol_uin <= head_job.u;
            sol_a   <= head_job.a;
            sol_dx  <= head_job.dx;
            state   <= LOAD;
          end
        end

        LOAD: begin
          // The solver latches its inputs at this edge; start the mirror.
          shadow_x <= sol_xin;
          iter     <= '0;
          state    <= RUN;
        end

        RUN: begin
          if (x_below_a) begin
            if (iter == ITER_LIMIT) begin
              tmo   <= 1'b1;
              state <= DONE;
            end else begin
              // Modular add matches the solver, including wrap-around.
              shadow_x <= shadow_x + sol_dx;
              iter     <= iter + 1'b1;
            end
          end else begin
            // The solver writes Xout/Yout/Uout at this same edge.
            tmo   <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          if (tmo) begin
            res_x <= shadow_x;
            res_y <= '0;
            res_u <= '0;
          end else begin
            res_x <= sol_xout;
            res_y <= sol_yout;
            res_u <= sol_uout;
          end
          res_timeout <= tmo;
          res_valid   <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_job_sequencer.sv
// Self-checking bench for diffeq_job_sequencer. A behavioural solver model
// is attached to the solver ports. Accepted jobs push their expected result
// (from a plain-arithmetic reference model) into a scoreboard queue; a
// separate monitor pops and compares on every result handshake, and also
// checks result hold and operand stability while the solver runs.
module tb_diffeq_job_sequencer;

  localparam int W        = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_ITER = 16;

  typedef struct {
    logic [W-1:0] x, y, u, a, dx;
  } job_s;

  typedef struct {
    logic [W-1:0] x, y, u;
    logic         tmo;
  } res_s;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid, job_ready;
  logic [W-1:0] job_x, job_y, job_u, job_a, job_dx;
  logic         res_valid, res_ready;
  logic [W-1:0] res_x, res_y, res_u;
  logic         res_timeout;
  logic         sol_reset;
  logic [W-1:0] sol_xin, sol_yin, sol_uin, sol_a, sol_dx;
  logic [W-1:0] sol_xout, sol_yout, sol_uout;

  int   checks = 0;
  int   errors = 0;
  res_s exp_q[$];
  int   rr_mode = 0;

  always #5 clk = ~clk;

  diffeq_job_sequencer #(
    .WIDTH    (W),
    .DEPTH    (DEPTH),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_x       (job_x),
    .job_y       (job_y),
    .job_u       (job_u),
    .job_a       (job_a),
    .job_dx      (job_dx),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_x       (res_x),
    .res_y       (res_y),
    .res_u       (res_u),
    .res_timeout (res_timeout),
    .sol_reset   (sol_reset),
    .sol_xin     (sol_xin),
    .sol_yin     (sol_yin),
    .sol_uin     (sol_uin),
    .sol_a       (sol_a),
    .sol_dx      (sol_dx),
    .sol_xout    (sol_xout),
    .sol_yout    (sol_yout),
    .sol_uout    (sol_uout)
  );

  // Behavioural diffeq solver: loads inputs on its first cycle out of reset,
  // iterates while x < a, then publishes its outputs.
  logic         s_started;
  logic [W-1:0] sx, sy, su;
  always @(posedge clk) begin
    if (sol_reset) begin
      s_started <= 1'b0;
    end else if (!s_started) begin
      sx <= sol_xin; sy <= sol_yin; su <= sol_uin;
      s_started <= 1'b1;
    end else if (sx < sol_a) begin
      sx <= sx + sol_dx;
      su <= su - 3 * sx * su * sol_dx - 3 * sy * sol_dx;
      sy <= sy + su * sol_dx;
    end else begin
      sol_xout <= sx; sol_yout <= sy; sol_uout <= su;
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic job_s mk(input logic [W-1:0] x, y, u, a, dx);
    job_s j;
    j.x = x; j.y = y; j.u = u; j.a = a; j.dx = dx;
    return j;
  endfunction

  // Reference: run the diffeq loop directly, aborting after MAX_ITER adds.
  function automatic res_s model(input job_s j);
    logic [W-1:0] x, y, u, xn, yn, un;
    int   n;
    res_s r;
    x = j.x; y = j.y; u = j.u; n = 0; r.tmo = 1'b0;
    while (x < j.a && !r.tmo) begin
      if (n == MAX_ITER) begin
        r.tmo = 1'b1;
      end else begin
        xn = x + j.dx;
        un = u - 3 * x * u * j.dx - 3 * y * j.dx;
        yn = y + u * j.dx;
        x = xn; y = yn; u = un;
        n++;
      end
    end
    r.x = x;
    r.y = r.tmo ? '0 : y;
    r.u = r.tmo ? '0 : u;
    return r;
  endfunction

  // Offer one job until accepted; expected result enters the scoreboard.
  task automatic send_job(input job_s j, output int waited);
    logic accepted;
    accepted = 1'b0;
    waited   = 0;
    job_x = j.x; job_y = j.y; job_u = j.u; job_a = j.a; job_dx = j.dx;
    job_valid = 1'b1;
    while (!accepted && waited < 500) begin
      @(negedge clk);
      if (job_ready) begin
        exp_q.push_back(model(j));
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (!accepted) waited++;
    end
    job_valid = 1'b0;
    check("job_accepted", accepted, 1'b1);
  endtask

  // Count edges until res_valid; sample sol_reset in the last RUN and DONE cycles.
  task automatic wait_result(input int exp_k, output int k, output logic sr_run, output logic sr_done);
    k = 0; sr_run = 1'bx; sr_done = 1'bx;
    while (!res_valid && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (k == exp_k - 2) sr_run  = sol_reset;
      if (k == exp_k - 1) sr_done = sol_reset;
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || res_valid) && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_scoreboard_empty", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // res_ready driver: 0 low, 1 high, 2 random, 3 one pulse every 4 cycles.
  initial begin
    int pulse_cnt;
    pulse_cnt = 0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        2:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = (pulse_cnt % 4 == 0);
      endcase
      pulse_cnt++;
    end
  end

  // Monitor: scoreboard compare on handshake, hold and stability checks.
  initial begin
    logic         prev_valid, prev_hs, prev_busy, hs;
    logic [96:0]  prev_res;
    logic [159:0] prev_ops;
    res_s         e;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_busy = 1'b0;
    prev_res = '0; prev_ops = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (prev_valid && !prev_hs) begin
          check("res_valid_held", res_valid, 1'b1);
          check("res_data_held", {res_timeout, res_x, res_y, res_u}, prev_res);
        end
        hs = res_valid && res_ready;
        if (hs) begin
          check("sb_result_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_res_x", res_x, e.x);
            check("sb_res_y", res_y, e.y);
            check("sb_res_u", res_u, e.u);
            check("sb_res_timeout", res_timeout, e.tmo);
          end
        end
        if (!sol_reset && prev_busy)
          check("sol_ops_stable", {sol_xin, sol_yin, sol_uin, sol_a, sol_dx}, prev_ops);
        prev_valid = res_valid;
        prev_hs    = hs;
        prev_res   = {res_timeout, res_x, res_y, res_u};
        prev_busy  = !sol_reset;
        prev_ops   = {sol_xin, sol_yin, sol_uin, sol_a, sol_dx};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int   w, k, cnt;
    logic sr_run, sr_done;
    job_s j;

    reset = 1'b1; job_valid = 1'b0;
    job_x = '0; job_y = '0; job_u = '0; job_a = '0; job_dx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_job_ready", job_ready, 1'b1);
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_res_data", {res_timeout, res_x, res_y, res_u}, 0);
    check("reset_sol_reset", sol_reset, 1'b1);
    check("reset_sol_ops", {sol_xin, sol_yin, sol_uin, sol_a, sol_dx}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_sol_reset", sol_reset, 1'b1);
    rr_mode = 1;

    // Three adds: 0 -> 3 with the textbook diffeq values.
    send_job(mk(0, 0, 1, 3, 1), w);
    wait_result(7, k, sr_run, sr_done);
    check("t1_latency", k, 7);
    check("t1_res_x", res_x, 32'd3);
    check("t1_res_y", res_y, 32'hFFFF_FFFD);
    check("t1_res_u", res_u, 32'd19);
    check("t1_res_timeout", res_timeout, 1'b0);
    wait_drain();

    // X >= A at start: no adds, outputs equal inputs.
    send_job(mk(5, 7, 9, 5, 2), w);
    wait_result(4, k, sr_run, sr_done);
    check("t2_latency", k, 4);
    check("t2_res_xyu", {res_x, res_y, res_u}, {32'd5, 32'd7, 32'd9});
    check("t2_res_timeout", res_timeout, 1'b0);
    wait_drain();

    // DX=0 watchdog abort, followed by a queued normal job.
    send_job(mk(0, 0, 0, 1, 0), w);
    send_job(mk(2, 1, 1, 4, 1), w);
    wait_result(MAX_ITER + 3, k, sr_run, sr_done);
    check("t3_latency", k, MAX_ITER + 3);
    check("t3_sol_reset_run", sr_run, 1'b0);
    check("t3_sol_reset_done", sr_done, 1'b1);
    check("t3_res_xyu", {res_x, res_y, res_u}, 0);
    check("t3_res_timeout", res_timeout, 1'b1);
    wait_drain();

    // Shadow x wraps to small values that stay below A: watchdog fires.
    send_job(mk(32'hFFFF_FFF0, 3, 4, 32'hFFFF_FFFF, 32'h10), w);
    wait_result(MAX_ITER + 4, k, sr_run, sr_done);
    check("t4_latency", k, MAX_ITER + 4);
    check("t4_res_x", res_x, 32'hF0);
    check("t4_res_timeout", res_timeout, 1'b1);
    wait_drain();

    // Backpressure: 4 stored plus 1 in flight, then job_ready drops.
    rr_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send_job(mk(32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 2), 1), w);
      check("bp_accept_immediate", w, 0);
    end
    check("bp_job_ready_low", job_ready, 1'b0);
    rr_mode = 3;
    send_job(mk(7, 1, 2, 9, 1), w);
    check("bp_job6_stalled", w > 0, 1'b1);
    rr_mode = 1;
    wait_drain();

    // Randomized jobs with random gaps and random result backpressure.
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7)
        j = mk(32'($urandom_range(0, 15)), $urandom, $urandom,
               32'($urandom_range(0, 30)), 32'($urandom_range(0, 4)));
      else
        j = mk($urandom, $urandom, $urandom, $urandom, $urandom);
      send_job(j, w);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rr_mode = 1;
    wait_drain();

    // Reset during RUN with two jobs queued behind the running one.
    send_job(mk(0, 0, 1, 1, 0), w);
    send_job(mk(1, 1, 1, 3, 1), w);
    send_job(mk(2, 2, 2, 4, 1), w);
    repeat (4) begin @(posedge clk); #1; end
    check("mid_run_sol_reset_low", sol_reset, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_sol_reset_comb", sol_reset, 1'b1);
    @(posedge clk); #1;
    check("post_reset_job_ready", job_ready, 1'b1);
    check("post_reset_res_valid", res_valid, 1'b0);
    check("post_reset_sol_reset", sol_reset, 1'b1);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) cnt++;
    end
    check("flushed_no_results", cnt, 0);
    check("flushed_idle_sol_reset", sol_reset, 1'b1);
    send_job(mk(1, 2, 3, 3, 1), w);
    wait_result(6, k, sr_run, sr_done);
    check("post_reset_latency", k, 6);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
